dl11_console: RTL and testbench

- Q-bus-style responder implementing a DL11-compatible console at 177560–177566 (octal) for the vm1 CPU.
- Answers the CPU's SYNC/DIN/DOUT/WTBT handshake with RPLY.
- Serialises XBUF writes onto an 8N1 TX line and accepts received bytes from a parallel host port.
- Raises VIRQ and supplies the vector on the interrupt-acknowledge cycle; replaces behavioural console models in benches and top level.

---
 rtl/dl11_console.sv | 224 ++++++++++++++++++++++
 tb/tb_dl11_console.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dl11_console.sv
// DL11-compatible console responder for the vm1 Q-bus handshake.
// Four registers at BASE_ADDR: RCSR, RBUF, XCSR, XBUF. Transmit bytes are
// serialised 8N1 on txd; receive bytes arrive on a parallel host port.
module dl11_console #(
   parameter int          CLKS_PER_BIT = 16,
   parameter logic [15:0] BASE_ADDR    = 16'o177560,
   parameter logic [15:0] RX_VECTOR    = 16'o060,
   parameter logic [15:0] TX_VECTOR    = 16'o064
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] addr_i,
   input  logic [15:0] data_i,
   output logic [15:0] data_o,
   input  logic        SYNC,
   input  logic        DIN,
   input  logic        DOUT,
   input  logic        WTBT,
   input  logic        INIT,
   input  logic        IAKO,
   output logic        RPLY,
   output logic        VIRQ,
   output logic        txd,
   output logic        tx_strobe,
   output logic [7:0]  tx_byte,
   input  logic        rx_valid,
   input  logic [7:0]  rx_byte
);

   localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_t;

   // bus / reply state
   logic            r_rply;
   logic [15:0]     r_vec;
   // receive side
   logic            r_done, r_err, r_rie;
   logic [7:0]      r_rbuf;
   // transmit side
   logic            r_tie, r_ready, r_tx_req;
   logic            r_tx_strobe;
   logic [7:0]      r_tx_byte;
   logic [7:0]      r_shift;
   tx_state_t       r_state;
   logic [CW-1:0]   r_cnt;
   logic [2:0]      r_bit;
   logic            r_txd;

   logic            w_clr, w_sel, w_req, w_fire;
   logic            w_bus_wr, w_bus_rd, w_iack, w_ack_tx;
   logic            w_rd_rbuf, w_wr_rcsr, w_wr_xcsr, w_wr_xbuf, w_accept;
   logic            w_irq_rx, w_stop_end, w_bit_end;
   logic            w_tie_nxt, w_ready_nxt;
   logic [1:0]      w_reg;
   logic [15:0]     w_vec;
   logic            w_unused;

   assign w_clr      = reset | INIT;
   assign w_sel      = SYNC & (addr_i[15:3] == BASE_ADDR[15:3]);
   assign w_reg      = addr_i[2:1];
   assign w_irq_rx   = r_done & r_rie;
   assign w_vec      = w_irq_rx ? RX_VECTOR : (r_tx_req ? TX_VECTOR : 16'd0);

   assign w_req      = (w_sel & (DIN | DOUT)) | (IAKO & DIN & VIRQ);
   // side effects happen only on the cycle that raises RPLY
   assign w_fire     = w_req & ~r_rply;
   // odd-byte writes are acknowledged but never land in a register
   assign w_bus_wr   = w_fire & w_sel & DOUT & ~(WTBT & addr_i[0]);
   assign w_bus_rd   = w_fire & w_sel & DIN;
   assign w_iack     = w_fire & ~w_sel & IAKO & DIN;
   assign w_ack_tx   = w_iack & ~w_irq_rx & r_tx_req;

   assign w_rd_rbuf  = w_bus_rd & (w_reg == 2'd1);
   assign w_wr_rcsr  = w_bus_wr & (w_reg == 2'd0);
   assign w_wr_xcsr  = w_bus_wr & (w_reg == 2'd2);
   assign w_wr_xbuf  = w_bus_wr & (w_reg == 2'd3);
   assign w_accept   = w_wr_xbuf & r_ready;

   assign w_bit_end  = (r_cnt == LAST);
   assign w_stop_end = (r_state == S_STOP) & w_bit_end;
   assign w_tie_nxt  = w_wr_xcsr ? data_i[6] : r_tie;
   assign w_ready_nxt = w_accept ? 1'b0 : (w_stop_end ? 1'b1 : r_ready);

   assign RPLY      = r_rply;
   assign VIRQ      = w_irq_rx | r_tx_req;
   assign txd       = r_txd;
   assign tx_strobe = r_tx_strobe;
   assign tx_byte   = r_tx_byte;
   assign w_unused  = &{1'b0, data_i[15:8]};

   // read mux; the acknowledge vector is frozen once RPLY is up because
   // a tx acknowledge clears the request that selected it
   always_comb begin
      data_o = 16'd0;
      if (w_sel & DIN) begin
         case (w_reg)
            2'd0:    data_o = {r_err, 7'd0, r_done, r_rie, 6'd0};
            2'd1:    data_o = {8'd0, r_rbuf};
            2'd2:    data_o = {8'd0, r_ready, r_tie, 6'd0};
            default: data_o = 16'd0;
         endcase
      end else if (IAKO & DIN) begin
         data_o = r_rply ? r_vec : w_vec;
      end
   end

   // reply handshake: raise after a request, drop once both strobes are low
   always_ff @(posedge clk) begin
      if (w_clr) begin
         r_rply <= 1'b0;
      end else if (w_fire) begin
         r_rply <= 1'b1;
      end else if (r_rply & ~DIN & ~DOUT) begin
         r_rply <= 1'b0;
      end
   end

   // vector captured at acknowledge time
   always_ff @(posedge clk) begin
      if (w_fire) r_vec <= w_vec;
   end

   // receive status: a new byte always wins over a simultaneous RBUF read
   always_ff @(posedge clk) begin
      if (w_clr) begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         r_rie  <= 1'b0;
      end else begin
         if (w_wr_rcsr) r_rie <= data_i[6];
         if (rx_valid) begin
            r_done <= 1'b1;
            if (w_rd_rbuf)   r_err <= 1'b0;
            else if (r_done) r_err <= 1'b1;
         end else if (w_rd_rbuf) begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
         end
      end
   end

   // receive data buffer
   always_ff @(posedge clk) begin
      if (rx_valid & ~w_clr) r_rbuf <= rx_byte;
   end

   // transmit data: byte latch and LSB-first shift register
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_tx_byte <= data_i[7:0];
         r_shift   <= data_i[7:0];
      end else if ((r_state == S_DATA) & w_bit_end) begin
         r_shift   <= {1'b0, r_shift[7:1]};
      end
   end

   // transmit control, interrupt request and 8N1 shifter
   always_ff @(posedge clk) begin
      if (w_clr) begin
         r_tie       <= 1'b0;
         r_ready     <= 1'b1;
         r_tx_req    <= 1'b0;
         r_tx_strobe <= 1'b0;
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_bit       <= 3'd0;
         r_txd       <= 1'b1;
      end else begin
         r_tie       <= w_tie_nxt;
         r_ready     <= w_ready_nxt;
         r_tx_strobe <= w_accept;
         r_tx_req    <= (r_tx_req & ~(w_ack_tx | ~w_tie_nxt | w_accept)) |
                        (w_tie_nxt & w_ready_nxt & ~(r_tie & r_ready));
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_state <= S_START;
                  r_cnt   <= '0;
                  r_txd   <= 1'b0;
               end
            end
            S_START: begin
               if (w_bit_end) begin
                  r_cnt   <= '0;
                  r_bit   <= 3'd0;
                  r_state <= S_DATA;
                  r_txd   <= r_shift[0];
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_DATA: begin
               if (w_bit_end) begin
                  r_cnt <= '0;
                  if (r_bit == 3'd7) begin
                     r_state <= S_STOP;
                     r_txd   <= 1'b1;
                  end else begin
                     r_bit <= r_bit + 3'd1;
                     r_txd <= r_shift[1];
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_STOP: begin
               if (w_bit_end) begin
                  r_cnt   <= '0;
                  r_state <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_txd   <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dl11_console.sv
// Self-checking bench for dl11_console: register table, hand-written
// frame / interrupt / INIT sequences, and a randomized run against a model.
module tb_dl11_console;

   localparam int CPB = 16;
   localparam logic [15:0] RCSR = 16'o177560;
   localparam logic [15:0] RBUF = 16'o177562;
   localparam logic [15:0] XCSR = 16'o177564;
   localparam logic [15:0] XBUF = 16'o177566;

   logic        clk = 1'b0;
   logic        reset, SYNC, DIN, DOUT, WTBT, INIT, IAKO, rx_valid;
   logic [15:0] addr_i, data_i, data_o;
   logic [7:0]  rx_byte, tx_byte;
   logic        RPLY, VIRQ, txd, tx_strobe;

   dl11_console #(.CLKS_PER_BIT(CPB)) dut (
      .clk(clk), .reset(reset), .addr_i(addr_i), .data_i(data_i),
      .data_o(data_o), .SYNC(SYNC), .DIN(DIN), .DOUT(DOUT), .WTBT(WTBT),
      .INIT(INIT), .IAKO(IAKO), .RPLY(RPLY), .VIRQ(VIRQ), .txd(txd),
      .tx_strobe(tx_strobe), .tx_byte(tx_byte), .rx_valid(rx_valid),
      .rx_byte(rx_byte)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   int n_chk = 0;
   int n_fail = 0;
   int strobe_cnt = 0;
   int strobe_cyc = -1;
   logic [7:0] strobe_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   // record every accepted byte and the edge it was accepted on
   always @(posedge clk) begin
      #1;
      if (tx_strobe) begin
         strobe_cnt++;
         strobe_cyc = cyc;
         strobe_q.push_back(tx_byte);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0o, expected %0o (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int t);
      if (cyc > t) begin
         n_chk++;
         n_fail++;
         $display("FAIL wait_until: at cycle %0d, required %0d", cyc, t);
      end
      while (cyc < t) tick();
   endtask

   task automatic bus_rd(input logic [15:0] a, input bit rep, output logic [15:0] d);
      addr_i = a; SYNC = 1'b1; DIN = 1'b1;
      tick();
      chk("rd_rply", RPLY, rep);
      d = data_o;
      tick();
      chk("rd_rply_hold", RPLY, rep);
      if (!rep) chk("rd_float", data_o, 16'd0);
      DIN = 1'b0; SYNC = 1'b0;
      tick();
      chk("rd_rply_drop", RPLY, 1'b0);
      chk("rd_idle_data", data_o, 16'd0);
   endtask

   task automatic bus_wr(input logic [15:0] a, input logic [15:0] d, input bit wt,
                         input bit rep, output int c);
      addr_i = a; data_i = d; WTBT = wt; SYNC = 1'b1; DOUT = 1'b1;
      tick();
      c = cyc;
      chk("wr_rply", RPLY, rep);
      tick();
      chk("wr_rply_hold", RPLY, rep);
      DOUT = 1'b0; SYNC = 1'b0; WTBT = 1'b0;
      tick();
      chk("wr_rply_drop", RPLY, 1'b0);
   endtask

   task automatic iack(input bit rep, input logic [15:0] vec);
      IAKO = 1'b1; DIN = 1'b1;
      tick();
      chk("iack_rply", RPLY, rep);
      chk("iack_vec", data_o, rep ? vec : 16'd0);
      tick();
      IAKO = 1'b0; DIN = 1'b0;
      tick();
      chk("iack_rply_drop", RPLY, 1'b0);
   endtask

   task automatic rx_pulse(input logic [7:0] b);
      rx_byte = b; rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
   endtask

   // expected line level in bit slot k of a frame: start, 8 data LSB first, stop
   task automatic frame_bits(input int c0, input logic [7:0] b, input int k0, input int k1);
      logic e;
      for (int k = k0; k <= k1; k++) begin
         wait_until(c0 + CPB * k + CPB / 2);
         if (k == 0)      e = 1'b0;
         else if (k == 9) e = 1'b1;
         else             e = b[k-1];
         chk($sformatf("txd_bit%0d", k), txd, e);
      end
   endtask

   typedef struct {
      bit          wr;
      logic [15:0] a;
      logic [15:0] d;
      bit          wtbt;
      bit          rep;
      logic [15:0] exp;
      bit          virq;
   } vec_t;

   vec_t tbl[16];

   // behavioural model state for the randomized run
   bit          m_done, m_err, m_rie, m_tie, m_ready, m_txreq, m_rbuf_ok;
   logic [7:0]  m_rbuf;
   int          m_ready_at;

   function automatic void m_sync(input int at);
      if (!m_ready && at >= m_ready_at) begin
         m_ready = 1'b1;
         if (m_tie) m_txreq = 1'b1;
      end
   endfunction

   logic [15:0] rd;
   int          c0, c1, c2, c3, wc, n0;

   initial begin
      reset = 1'b1; SYNC = 0; DIN = 0; DOUT = 0; WTBT = 0; INIT = 0; IAKO = 0;
      rx_valid = 0; rx_byte = 0; addr_i = 0; data_i = 0;
      tick(); tick(); tick();
      reset = 1'b0;
      chk("rst_txd", txd, 1'b1);
      chk("rst_rply", RPLY, 1'b0);
      chk("rst_virq", VIRQ, 1'b0);
      chk("rst_strobe", tx_strobe, 1'b0);
      chk("rst_data", data_o, 16'd0);

      // ---------------- register table ----------------
      tbl[0]  = '{1'b0, XCSR,           16'd0,       1'b0, 1'b1, 16'o200, 1'b0};
      tbl[1]  = '{1'b0, RCSR,           16'd0,       1'b0, 1'b1, 16'o000, 1'b0};
      tbl[2]  = '{1'b0, XBUF,           16'd0,       1'b0, 1'b1, 16'o000, 1'b0};
      tbl[3]  = '{1'b1, RCSR,           16'o177777,  1'b0, 1'b1, 16'o000, 1'b0};
      tbl[4]  = '{1'b0, RCSR,           16'd0,       1'b0, 1'b1, 16'o100, 1'b0};
      tbl[5]  = '{1'b1, 16'o177561,     16'o000000,  1'b1, 1'b1, 16'o000, 1'b0};
      tbl[6]  = '{1'b0, RCSR,           16'd0,       1'b0, 1'b1, 16'o100, 1'b0};
      tbl[7]  = '{1'b1, RCSR,           16'o177400,  1'b1, 1'b1, 16'o000, 1'b0};
      tbl[8]  = '{1'b0, RCSR,           16'd0,       1'b0, 1'b1, 16'o000, 1'b0};
      tbl[9]  = '{1'b1, XCSR,           16'o100,     1'b0, 1'b1, 16'o000, 1'b1};
      tbl[10] = '{1'b0, XCSR,           16'd0,       1'b0, 1'b1, 16'o300, 1'b1};
      tbl[11] = '{1'b1, XCSR,           16'o000,     1'b0, 1'b1, 16'o000, 1'b0};
      tbl[12] = '{1'b0, XCSR,           16'd0,       1'b0, 1'b1, 16'o200, 1'b0};
      tbl[13] = '{1'b0, 16'o177570,     16'd0,       1'b0, 1'b0, 16'o000, 1'b0};
      tbl[14] = '{1'b0, 16'o177556,     16'd0,       1'b0, 1'b0, 16'o000, 1'b0};
      tbl[15] = '{1'b1, 16'o177570,     16'o101,     1'b0, 1'b0, 16'o000, 1'b0};
      for (int i = 0; i < 16; i++) begin
         if (tbl[i].wr) begin
            bus_wr(tbl[i].a, tbl[i].d, tbl[i].wtbt, tbl[i].rep, wc);
         end else begin
            bus_rd(tbl[i].a, tbl[i].rep, rd);
            if (tbl[i].rep) chk($sformatf("tbl%0d_data", i), rd, tbl[i].exp);
         end
         chk($sformatf("tbl%0d_virq", i), VIRQ, tbl[i].virq);
      end
      chk("tbl_no_strobe", strobe_cnt, 0);

      // ---------------- transmit frame 'o101 ----------------
      bus_wr(XBUF, 16'o101, 1'b0, 1'b1, c0);
      tick();
      chk("txA_strobe_cnt", strobe_cnt, 1);
      chk("txA_strobe_cyc", strobe_cyc, c0);
      chk("txA_byte", strobe_q[strobe_q.size()-1], 8'h41);
      frame_bits(c0, 8'h41, 0, 4);
      bus_rd(XCSR, 1'b1, rd);
      chk("txA_xcsr_busy", rd, 16'd0);
      bus_wr(XBUF, 16'h42, 1'b0, 1'b1, wc);
      tick();
      chk("txA_drop_strobe", strobe_cnt, 1);
      frame_bits(c0, 8'h41, 5, 9);
      wait_until(c0 + 157);
      addr_i = XCSR; SYNC = 1'b1; DIN = 1'b1;
      tick();
      chk("txA_rd_rply", RPLY, 1'b1);
      tick();
      chk("txA_xcsr_159", data_o, 16'd0);
      tick();
      chk("txA_xcsr_160", data_o, 16'o200);
      DIN = 1'b0; SYNC = 1'b0;
      tick();
      chk("txA_rply_drop", RPLY, 1'b0);
      chk("txA_idle_txd", txd, 1'b1);
      bus_wr(16'o177567, 16'h4300, 1'b1, 1'b1, wc);
      tick();
      chk("txA_oddbyte_strobe", strobe_cnt, 1);
      bus_rd(XCSR, 1'b1, rd);
      chk("txA_oddbyte_xcsr", rd, 16'o200);

      // ---------------- transmit interrupt ----------------
      bus_wr(XCSR, 16'o100, 1'b0, 1'b1, wc);
      chk("txI_virq_set", VIRQ, 1'b1);
      iack(1'b1, 16'o064);
      chk("txI_virq_ack", VIRQ, 1'b0);
      bus_wr(XBUF, 16'o102, 1'b0, 1'b1, c1);
      chk("txI_virq_busy", VIRQ, 1'b0);
      wait_until(c1 + 159);
      chk("txI_virq_159", VIRQ, 1'b0);
      tick();
      chk("txI_virq_160", VIRQ, 1'b1);
      bus_wr(XCSR, 16'o000, 1'b0, 1'b1, wc);
      chk("txI_virq_tie0", VIRQ, 1'b0);

      // ---------------- receive path ----------------
      bus_wr(RCSR, 16'o100, 1'b0, 1'b1, wc);
      rx_pulse(8'h55);
      chk("rx_virq", VIRQ, 1'b1);
      rx_pulse(8'h66);
      bus_rd(RCSR, 1'b1, rd);
      chk("rx_overrun_rcsr", rd, 16'o100300);
      iack(1'b1, 16'o060);
      chk("rx_virq_after_iack", VIRQ, 1'b1);
      bus_rd(RBUF, 1'b1, rd);
      chk("rx_rbuf", rd, 16'o146);
      bus_rd(RCSR, 1'b1, rd);
      chk("rx_rcsr_clr", rd, 16'o100);
      chk("rx_virq_clr", VIRQ, 1'b0);
      rx_pulse(8'h11);
      rx_pulse(8'h22);
      addr_i = RBUF; SYNC = 1'b1; DIN = 1'b1; rx_byte = 8'h33; rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
      chk("rxc_rply", RPLY, 1'b1);
      chk("rxc_newbyte", data_o, 16'h0033);
      DIN = 1'b0; SYNC = 1'b0;
      tick();
      bus_rd(RCSR, 1'b1, rd);
      chk("rxc_rcsr", rd, 16'o300);
      bus_rd(RBUF, 1'b1, rd);
      chk("rxc_rbuf", rd, 16'h0033);
      bus_rd(RCSR, 1'b1, rd);
      chk("rxc_rcsr2", rd, 16'o100);

      // ---------------- INIT in the middle of a frame ----------------
      rx_pulse(8'h77);
      bus_wr(XCSR, 16'o100, 1'b0, 1'b1, wc);
      chk("init_pre_virq", VIRQ, 1'b1);
      bus_wr(XBUF, 16'h00, 1'b0, 1'b1, c2);
      wait_until(c2 + 40);
      chk("init_pre_txd", txd, 1'b0);
      INIT = 1'b1;
      tick();
      INIT = 1'b0;
      chk("init_txd", txd, 1'b1);
      chk("init_virq", VIRQ, 1'b0);
      bus_rd(XCSR, 1'b1, rd);
      chk("init_xcsr", rd, 16'o200);
      bus_rd(RCSR, 1'b1, rd);
      chk("init_rcsr", rd, 16'o000);
      n0 = strobe_cnt;
      bus_wr(XBUF, 16'hA5, 1'b0, 1'b1, c3);
      tick();
      chk("init_strobe", strobe_cnt, n0 + 1);
      chk("init_strobe_byte", strobe_q[strobe_q.size()-1], 8'hA5);
      frame_bits(c3, 8'hA5, 0, 9);
      wait_until(c3 + 160);
      chk("init_ready_back", txd, 1'b1);
      bus_rd(XCSR, 1'b1, rd);
      chk("init_xcsr_end", rd, 16'o200);

      // ---------------- randomized run against the model ----------------
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      m_done = 0; m_err = 0; m_rie = 0; m_tie = 0; m_ready = 1; m_txreq = 0;
      m_rbuf_ok = 0; m_rbuf = 0; m_ready_at = 0;
      for (int it = 0; it < 250; it++) begin
         int          op;
         bit          wt, odd;
         logic [15:0] d;
         bit          old_rt;
         op = $urandom_range(0, 8);
         wt = 1'($urandom_range(0, 1));
         odd = wt & 1'($urandom_range(0, 1));
         d = 16'($urandom);
         // keep bus operations clear of the exact cycle READY returns
         if (!m_ready && cyc + 4 >= m_ready_at) wait_until(m_ready_at);
         m_sync(cyc);
         case (op)
            0: begin
               rx_pulse(d[7:0]);
               if (m_done) m_err = 1'b1;
               m_done = 1'b1; m_rbuf = d[7:0]; m_rbuf_ok = 1'b1;
            end
            1: begin
               bus_rd(RCSR, 1'b1, rd);
               chk("rnd_rcsr", rd, {m_err, 7'd0, m_done, m_rie, 6'd0});
            end
            2: begin
               if (m_rbuf_ok) begin
                  bus_rd(RBUF, 1'b1, rd);
                  chk("rnd_rbuf", rd, {8'd0, m_rbuf});
                  m_done = 1'b0; m_err = 1'b0;
               end
            end
            3: begin
               bus_wr(RCSR | 16'(odd), d, wt, 1'b1, wc);
               if (!odd) m_rie = d[6];
            end
            4: begin
               bus_rd(XCSR, 1'b1, rd);
               chk("rnd_xcsr", rd, {8'd0, m_ready, m_tie, 6'd0});
            end
            5: begin
               bus_wr(XCSR | 16'(odd), d, wt, 1'b1, wc);
               if (!odd) begin
                  old_rt = m_ready & m_tie;
                  m_tie = d[6];
                  if (!m_tie) m_txreq = 1'b0;
                  else if (m_ready && !old_rt) m_txreq = 1'b1;
               end
            end
            6: begin
               if (m_done & m_rie) begin
                  iack(1'b1, 16'o060);
               end else if (m_txreq) begin
                  iack(1'b1, 16'o064);
                  m_txreq = 1'b0;
               end else begin
                  iack(1'b0, 16'd0);
               end
            end
            7: begin
               n0 = strobe_cnt;
               bus_wr(XBUF | 16'(odd), d, wt, 1'b1, wc);
               if (!odd && m_ready) begin
                  m_ready = 1'b0; m_txreq = 1'b0; m_ready_at = wc + 10 * CPB;
                  chk("rnd_strobe", strobe_cnt, n0 + 1);
                  chk("rnd_strobe_byte", strobe_q[strobe_q.size()-1], d[7:0]);
               end else begin
                  chk("rnd_no_strobe", strobe_cnt, n0);
               end
            end
            default: begin
               for (int j = 0; j < int'($urandom_range(1, 40)); j++) tick();
            end
         endcase
         m_sync(cyc);
         chk("rnd_virq", VIRQ, (m_done & m_rie) | m_txreq);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
